// File: rtl/matrix_mac_engine.sv
// Matrix multiply engine: latches two N x N unsigned matrices, computes C = A x B
// with one time-multiplexed MAC, and streams C row-major over a valid/ready handshake.
module matrix_mac_engine #(
  parameter int N    = 10,
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*N*DW-1:0]   a_data,
  input  logic [N*N*DW-1:0]   b_data,
  output logic                busy,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [ACCW-1:0]     c_data,
  output logic [3:0]          c_row,
  output logic [3:0]          c_col,
  output logic                done
);

  localparam int NE = N * N;
  localparam int IDXW = $clog2(NE);
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   a_mem [NE];
  logic [DW-1:0]   b_mem [NE];
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_nxt;
  logic [3:0]      i_idx, j_idx, k_idx;
  logic [IDXW-1:0] a_sel, b_sel;
  logic [DW-1:0]   a_op, b_op;

  // Unsigned DW x DW product, zero-extended into the accumulator width.
  function automatic logic [ACCW-1:0] mac_add(input logic [ACCW-1:0] sum,
                                              input logic [DW-1:0]   x,
                                              input logic [DW-1:0]   y);
    logic [2*DW-1:0] prod;
    prod = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    return sum + ACCW'(prod);
  endfunction

  // Operand mux into the single multiplier: A(i,k) and B(k,j).
  always_comb begin
    a_sel   = IDXW'(int'(i_idx) * N + int'(k_idx));
    b_sel   = IDXW'(int'(k_idx) * N + int'(j_idx));
    a_op    = a_mem[a_sel];
    b_op    = b_mem[b_sel];
    acc_nxt = mac_add(acc, a_op, b_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (k_idx == LAST) state_nxt = OUT;
      OUT:     if (c_ready) state_nxt = (i_idx == LAST && j_idx == LAST) ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    c_valid = (state == OUT);
    done    = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      k_idx  <= '0;
      c_data <= '0;
      c_row  <= '0;
      c_col  <= '0;
      for (int e = 0; e < NE; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int e = 0; e < NE; e++) begin
              a_mem[e] <= a_data[e*DW +: DW];
              b_mem[e] <= b_data[e*DW +: DW];
            end
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (k_idx == LAST) begin
            c_data <= acc_nxt;
            c_row  <= i_idx;
            c_col  <= j_idx;
            k_idx  <= '0;
          end else begin
            k_idx <= k_idx + 4'd1;
          end
        end
        OUT: begin
          // Result registers hold until the consumer takes the element.
          if (c_ready) begin
            acc   <= '0;
            k_idx <= '0;
            if (j_idx == LAST) begin
              j_idx <= '0;
              i_idx <= (i_idx == LAST) ? 4'd0 : i_idx + 4'd1;
            end else begin
              j_idx <= j_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: matrix-level reference model plus a
// per-cycle monitor checking every transfer, hold stability and done pulses.
module tb_matrix_mac_engine;
  localparam int N    = 10;
  localparam int DW   = 8;
  localparam int ACCW = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start = 1'b0;
  logic              c_ready = 1'b0;
  logic [N*N*DW-1:0] a_data = '0;
  logic [N*N*DW-1:0] b_data = '0;
  logic              busy, c_valid, done;
  logic [ACCW-1:0]   c_data;
  logic [3:0]        c_row, c_col;

  matrix_mac_engine #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_data(a_data), .b_data(b_data),
    .busy(busy), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_row(c_row), .c_col(c_col), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: plain matrices and the row-major list of expected results.
  int ma [N][N];
  int mb [N][N];
  typedef struct {int r; int c; int d;} elem_t;
  elem_t exp_q[$];

  task automatic fill(input bit is_a, input int kind, input int v);
    int val;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (kind == 0)      val = (r == c) ? 1 : 0;
        else if (kind == 1) val = v;
        else                val = r * N + c;
        if (is_a) ma[r][c] = val;
        else      mb[r][c] = val;
      end
  endtask

  task automatic apply_model();
    elem_t e;
    exp_q.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_data[(r*N+c)*DW +: DW] = DW'(ma[r][c]);
        b_data[(r*N+c)*DW +: DW] = DW'(mb[r][c]);
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.r = r;
        e.c = c;
        e.d = 0;
        for (int k = 0; k < N; k++) e.d += ma[r][k] * mb[k][c];
        exp_q.push_back(e);
      end
  endtask

  // Monitor state
  int          xfers = 0;
  int          done_cnt = 0;
  int          first_vld = -1;
  int          done_cyc = -1;
  int          last_data = 0;
  int          start_edge = 0;
  bit          hold = 1'b0;
  logic [27:0] h_vec;

  initial begin
    elem_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold)
          chk("hold_stable", {3'b0, c_valid, c_row, c_col, c_data}, {3'b0, 1'b1, h_vec});
        hold  = c_valid && !c_ready;
        h_vec = {c_row, c_col, c_data};
        if (c_valid && first_vld < 0) first_vld = cyc;
        if (c_valid && c_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_transfer", {4'b0, c_row, c_col, c_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("transfer", {4'b0, c_row, c_col, c_data},
                {4'b0, 4'(e.r), 4'(e.c), 20'(e.d)});
            last_data = int'(c_data);
            xfers++;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_all_elements", exp_q.size(), 0);
        end
      end
    end
  end

  // ready_mode 0: c_ready held high; 1: high one cycle in four.
  task automatic run(input int ready_mode, input bit zero_a_after, input bit restart_mid);
    int  d0;
    bit  injected;
    bit  finished;
    d0        = done_cnt;
    xfers     = 0;
    first_vld = -1;
    done_cyc  = -1;
    injected  = 1'b0;
    finished  = 1'b0;
    c_ready   = (ready_mode == 0);
    @(posedge clk); #1;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (zero_a_after) a_data = '0;
    for (int t = 0; t < 6000 && !finished; t++) begin
      @(posedge clk); #1;
      if (ready_mode == 1) c_ready = (cyc % 4 == 0);
      if (restart_mid && !injected && xfers == 5) begin
        start    = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_cnt != d0) finished = 1'b1;
    end
    start = 1'b0;
    chk("run_completed_in_budget", finished, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("transfer_count", xfers, 100);
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("idle_after_run", {busy, c_valid}, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {busy, c_valid, done, c_row, c_col, c_data}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Identity x (r*N+c)
    fill(1, 0, 0);
    fill(0, 2, 0);
    apply_model();
    chk("model_pin_identity", exp_q[37].d, 37);
    run(0, 0, 0);
    chk("first_valid_latency", first_vld - start_edge, 10);
    chk("done_edge_offset", done_cyc - start_edge, 1100);
    chk("identity_last", last_data, 99);

    // Max operands
    fill(1, 1, 255);
    fill(0, 1, 255);
    apply_model();
    chk("model_pin_max", exp_q[0].d, 650250);
    run(0, 0, 0);
    chk("max_last", last_data, 32'h9EC0A);

    // Back-pressure with all-ones
    fill(1, 1, 1);
    fill(0, 1, 1);
    apply_model();
    run(1, 0, 0);
    chk("backpressure_last", last_data, 10);

    // Operand latching: A changes to zero after start
    fill(1, 1, 2);
    fill(0, 1, 2);
    apply_model();
    run(0, 1, 0);
    chk("latched_last", last_data, 40);

    // Reset during element (3,4)
    begin
      int d0;
      bit reached;
      fill(1, 0, 0);
      fill(0, 2, 0);
      apply_model();
      d0      = done_cnt;
      xfers   = 0;
      reached = 1'b0;
      c_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 0; t < 2000 && !reached; t++) begin
        @(posedge clk); #1;
        if (xfers == 34) reached = 1'b1;
      end
      chk("reached_element_3_4", reached, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", {busy, c_valid, done, c_row, c_col, c_data}, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt - d0, 0);
      chk("idle_after_abort", {busy, c_valid}, 0);
    end

    fill(1, 0, 0);
    fill(0, 0, 0);
    apply_model();
    run(0, 0, 0);
    chk("identity_sq_last", last_data, 1);

    // Start pulsed again while busy
    fill(1, 0, 0);
    fill(0, 2, 0);
    apply_model();
    run(0, 0, 1);
    chk("restart_ignored_last", last_data, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_mac_engine.md
Name: matrix_mac_engine

Overview:
- Downstream consumer of the flat matrix-memory read bus: latches two N×N unsigned 8-bit matrices presented as flat buses, computes C = A×B with a single time-multiplexed multiply-accumulate unit, and streams C one element per transfer over a valid/ready handshake in row-major order.
- Sits between the A/B matrix memories and the result writer or UART/LED output stage.

Parameters:
- N, 10, matrix dimension; rows = cols = N.
- DW, 8, operand element width in bits, unsigned.
- ACCW, 20, accumulator/result width. Must be ≥ 2*DW + clog2(N); 20 for the defaults.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a multiply; sampled only in IDLE.
- a_data  in  N*N*DW  matrix A. Element (r,c) is at bits [(r*N+c)*DW +: DW], so element 0 is in the LSBs.
- b_data  in  N*N*DW  matrix B, same packing as a_data.
- busy  out  1  high in every state except IDLE.
- c_valid  out  1  result element available.
- c_ready  in  1  consumer accepts the result element.
- c_data  out  ACCW  result element C(row,col).
- c_row  out  4  row index of c_data.
- c_col  out  4  column index of c_data.
- done  out  1  one-cycle pulse after the last element transfers.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0; c_valid=0; done=0; c_data=0; c_row=0; c_col=0; accumulator=0; i,j,k=0; operand registers=0.
- States and transitions:
  - IDLE -> MAC when start=1. That edge captures a_data and b_data into internal registers, clears the accumulator, and sets i=j=k=0. The upstream memory may change after this edge with no effect on the result.
  - MAC: each edge does acc += A(i,k)*B(k,j) as an unsigned DW×DW product, zero-extended to ACCW, then k++. On the edge where k=N-1, the block loads c_data with the final sum, sets c_row=i and c_col=j, asserts c_valid, and moves to OUT.
  - OUT: c_valid is held high. c_data, c_row and c_col stay stable until c_valid && c_ready on an edge.
    - On the transfer edge: c_valid=0, acc=0, k=0, and j advances. When j wraps at N-1 it returns to 0 and i++.
    - If the transferred element was (N-1,N-1), go to DONE; otherwise go to MAC.
  - DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Timing with c_ready held high:
  - The first c_valid is visible after the 10th edge following the start-sampling edge.
  - Each element takes N+1 = 11 cycles.
  - The final transfer occurs on edge 1100 after start, done is high during the next cycle, and the block is back in IDLE after edge 1101.
- Arithmetic: unsigned only; no saturation is needed because ACCW covers the maximum sum N*(2^DW-1)^2 = 650250.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - c_ready high outside OUT: no effect.
  - c_ready held low: the block stalls in OUT indefinitely with outputs stable and no data loss.
  - rst_n low mid-operation: immediate return to reset values. A partial result is never emitted and done is not pulsed.
  - start held high continuously: a new run begins on the edge after DONE, i.e. in the IDLE cycle.
- Operand selection uses muxing of the latched registers indexed by i, j and k. There is one multiplier instance in total.

Test Plan:
- Identity×B: A=I, B(r,c)=r*N+c, c_ready=1, pulse start -> 100 transfers in order (0,0)…(9,9), c_data=r*N+c, first c_valid 10 cycles after start, done pulses exactly once at cycle 1101.
- Max operands: all A=B=255 -> every c_data=650250 (0x9EC0A), no overflow, 100 transfers.
- Back-pressure: A=B=all 1, c_ready toggling 1 cycle high / 3 cycles low -> every c_data=10, outputs stable while c_valid&&!c_ready, exactly 100 transfers, no duplicates or drops.
- Operand latching: start with A=B=all 2, then change a_data to all 0 on the next cycle -> all results still 40.
- Reset mid-run: assert rst_n=0 during element (3,4) MAC -> c_valid=0, busy=0, done never pulses. A fresh start with A=I, B=I then yields c_data=1 on the diagonal and 0 elsewhere.
- start ignored while busy: pulse start again during element (0,5) -> single run, single done pulse, 100 transfers.
